// File: rtl/mul_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the multiplier arbiter.
package mul_arbiter_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned TIMEOUT_CYC = 20;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        BUSY,
        RESP
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner select: the scan starts one past last_grant.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   last_grant,
    output logic            found_c,
    output logic [IW-1:0]   winner_c
);

    // First requester found walking upward from last_grant+1, wrapping modulo NREQ.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found_c && req_valid[IW'((32'(last_grant) + k) % NREQ)]) begin
                found_c  = 1'b1;
                winner_c = IW'((32'(last_grant) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external sequential multiplier among NREQ requesters.
// Optional build macro MUL_ARBITER_TIMEOUT_EN adds a BUSY watchdog that answers with resp_err.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]    resp_product,
    output logic                  resp_err,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_multiplier,
    output logic [WIDTH-1:0]      mul_multiplicand,
    input  logic [2*WIDTH-1:0]    mul_product,
    input  logic                  mul_ready
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] op_a_d, op_b_d;
    logic [PW-1:0]    prod_d;
    logic [NREQ-1:0]  req_ready_d, resp_valid_d;
    logic             mul_start_d;
    logic             found_c;
    logic [IW-1:0]    winner_c;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

`ifdef MUL_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_d;
`endif

    // Split packed operand buses into per-requester slices.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .found_c    (found_c),
        .winner_c   (winner_c)
    );

    // Next state plus next values of every registered output; pulses default low.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        op_a_d       = mul_multiplier;
        op_b_d       = mul_multiplicand;
        prod_d       = resp_product;
        req_ready_d  = '0;
        resp_valid_d = '0;
        mul_start_d  = 1'b0;
`ifdef MUL_ARBITER_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d               = ISSUE;
                    gnt_d                 = winner_c;
                    last_d                = winner_c;
                    op_a_d                = a_arr[winner_c];
                    op_b_d                = b_arr[winner_c];
                    req_ready_d[winner_c] = 1'b1;
                    mul_start_d           = 1'b1;
                end
            end
            ISSUE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                // Multiplier may still show a stale ready here; wait a cycle before trusting it.
                state_d = BUSY;
`ifdef MUL_ARBITER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            BUSY: begin
                if (mul_ready) begin
                    state_d             = RESP;
                    prod_d              = mul_product;
                    resp_valid_d[gnt_q] = 1'b1;
                end
`ifdef MUL_ARBITER_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d             = RESP;
                    prod_d              = '0;
                    err_d               = 1'b1;
                    resp_valid_d[gnt_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            gnt_q            <= '0;
            last_q           <= IW'(NREQ - 1);
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            resp_product     <= '0;
            req_ready        <= '0;
            resp_valid       <= '0;
            mul_start        <= 1'b0;
        end else begin
            state_q          <= state_d;
            gnt_q            <= gnt_d;
            last_q           <= last_d;
            mul_multiplier   <= op_a_d;
            mul_multiplicand <= op_b_d;
            resp_product     <= prod_d;
            req_ready        <= req_ready_d;
            resp_valid       <= resp_valid_d;
            mul_start        <= mul_start_d;
        end
    end

`ifdef MUL_ARBITER_TIMEOUT_EN
    // BUSY watchdog counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            resp_err <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            resp_err <= err_d;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural sequential multiplier.
module tb_mul_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned PW    = 2 * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready, resp_valid;
    logic [PW-1:0]         resp_product;
    logic                  resp_err, mul_start, mul_ready;
    logic [WIDTH-1:0]      mul_multiplier, mul_multiplicand;
    logic [PW-1:0]         mul_product;

    logic signed [WIDTH-1:0] a_v [NREQ];
    logic signed [WIDTH-1:0] b_v [NREQ];

    typedef struct {
        int           idx;
        logic [PW-1:0] prod;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic stub_stuck = 1'b0;
    int unsigned mlat = 1;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_v[i];
            req_b[i*WIDTH +: WIDTH] = b_v[i];
        end
    end

    mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_product     (resp_product),
        .resp_err         (resp_err),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_ready        (mul_ready)
    );

    // Sequential multiplier model: ready pulses mlat cycles after the start pulse is seen.
    logic [PW-1:0] ma, mb;
    int unsigned   mcnt;
    always @(posedge clk) begin
        if (rst) begin
            mcnt        <= 0;
            mul_ready   <= 1'b0;
            mul_product <= '0;
            ma          <= '0;
            mb          <= '0;
        end else begin
            mul_ready <= 1'b0;
            if (mul_start) begin
                mcnt <= mlat;
                ma   <= {{WIDTH{mul_multiplier[WIDTH-1]}}, mul_multiplier};
                mb   <= {{WIDTH{mul_multiplicand[WIDTH-1]}}, mul_multiplicand};
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && !stub_stuck) begin
                    mul_ready   <= 1'b1;
                    mul_product <= ma * mb;
                end
            end
        end
    end

    // Scoreboard: push expectation on each grant, pop and compare on each response.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (req_ready != '0 || mul_start) begin
                n_tests++;
                if ($countones(req_ready) != 1 || mul_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL grant_pulse: req_ready=%b mul_start=%b, required one-hot ready with mul_start=1",
                             req_ready, mul_start);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        exp_t e;
                        e.idx = i;
                        if (stub_stuck) begin
                            e.prod = '0;
                            e.err  = 1'b1;
                        end else begin
                            e.prod = PW'(longint'(a_v[i]) * longint'(b_v[i]));
                            e.err  = 1'b0;
                        end
                        sb_q.push_back(e);
                        grant_log.push_back(i);
                    end
                end
            end
            if (resp_valid != '0) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid=%b with no outstanding grant", resp_valid);
                end else begin
                    exp_t e;
                    logic [NREQ-1:0] oh;
                    e  = sb_q.pop_front();
                    oh = NREQ'(1) << e.idx;
                    if (resp_valid !== oh || resp_product !== e.prod || resp_err !== e.err) begin
                        n_fail++;
                        $display("FAIL resp_match: got valid=%b prod=%0h err=%b, required valid=%b prod=%0h err=%b",
                                 resp_valid, resp_product, resp_err, oh, e.prod, e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic drain(output bit ok);
        int cyc = 0;
        while ((req_valid != '0 || sb_q.size() != 0) && cyc < 3000) begin
            tick();
            cyc++;
        end
        tick();
        ok = (cyc < 3000);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        sb_q.delete();
        grant_log.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        n_tests++; if (resp_valid !== '0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        n_tests++; if (resp_product !== '0) begin n_fail++; $display("FAIL rst_resp_product: got %0h required 0", resp_product); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
        n_tests++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_mul_start: got %b required 0", mul_start); end
        n_tests++; if (mul_multiplier !== '0) begin n_fail++; $display("FAIL rst_mul_multiplier: got %0h required 0", mul_multiplier); end
        n_tests++; if (mul_multiplicand !== '0) begin n_fail++; $display("FAIL rst_mul_multiplicand: got %0h required 0", mul_multiplicand); end
        rst = 1'b0;
    endtask

    // Single requester 0; also checks latency and that operand changes after grant are ignored.
    task automatic test_single();
        int            lat_tab [2] = '{1, 3};
        int            a_tab   [2] = '{10, -7};
        int            b_tab   [2] = '{-1, 3};
        logic [PW-1:0] p_tab   [2] = '{32'hFFFF_FFF6, 32'hFFFF_FFEB};
        int            exp_cyc [2] = '{4, 6};
        for (int t = 0; t < 2; t++) begin
            int cyc = 0;
            bit got = 0;
            mlat      = lat_tab[t];
            a_v[0]    = WIDTH'(a_tab[t]);
            b_v[0]    = WIDTH'(b_tab[t]);
            req_valid = 4'b0001;
            while (!got && cyc < 50) begin
                tick();
                cyc++;
                if (cyc == 1) begin
                    n_tests++;
                    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b required 0001", req_ready); end
                    a_v[0] = 16'sh1234;
                    b_v[0] = 16'sh0077;
                end
                if (resp_valid != '0) begin
                    got = 1;
                    n_tests++;
                    if (resp_valid !== 4'b0001 || resp_product !== p_tab[t] || resp_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL single_resp: got valid=%b prod=%0h err=%b required 0001 %0h 0",
                                 resp_valid, resp_product, resp_err, p_tab[t]);
                    end
                    n_tests++;
                    if (cyc != exp_cyc[t]) begin n_fail++; $display("FAIL single_latency: got %0d required %0d", cyc, exp_cyc[t]); end
                    n_tests++;
                    if (mul_multiplier !== WIDTH'(a_tab[t])) begin
                        n_fail++; $display("FAIL single_operand_hold: got %0h required %0h", mul_multiplier, WIDTH'(a_tab[t]));
                    end
                end
            end
            n_tests++;
            if (!got) begin n_fail++; $display("FAIL single_timeout: no response in 50 cycles"); end
            tick();
        end
    endtask

    task automatic test_all_four();
        bit ok;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = -16'sd100;
            b_v[i] = -16'sd1001;
        end
        mlat      = $urandom_range(1, 4);
        req_valid = '1;
        drain(ok);
        n_tests++;
        if (!ok || grant_log.size() != 4) begin
            n_fail++; $display("FAIL all4_count: got %0d grants required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (grant_log[i] != i) begin n_fail++; $display("FAIL all4_order[%0d]: got %0d required %0d", i, grant_log[i], i); end
            end
        end
    endtask

    task automatic test_rr_skip();
        bit ok1, ok2;
        int exp_g [3] = '{1, 3, 0};
        grant_log.delete();
        req_valid = 4'b0010;
        drain(ok1);
        req_valid = 4'b1001;
        drain(ok2);
        n_tests++;
        if (!ok1 || !ok2 || grant_log.size() != 3) begin
            n_fail++; $display("FAIL rr_skip_count: got %0d grants required 3", grant_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (grant_log[i] != exp_g[i]) begin n_fail++; $display("FAIL rr_skip[%0d]: got %0d required %0d", i, grant_log[i], exp_g[i]); end
            end
        end
    endtask

    task automatic test_reset_busy();
        int seen = 0;
        bit ok;
        mlat      = 10;
        a_v[2]    = 16'sd300;
        b_v[2]    = -16'sd5;
        req_valid = 4'b0100;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({req_ready, resp_valid, resp_product, resp_err, mul_start, mul_multiplier, mul_multiplicand} !== '0) begin
            n_fail++;
            $display("FAIL busy_rst_outputs: got ready=%b valid=%b prod=%0h err=%b start=%b ma=%0h mb=%0h required all 0",
                     req_ready, resp_valid, resp_product, resp_err, mul_start, mul_multiplier, mul_multiplicand);
        end
        rst       = 1'b0;
        req_valid = '0;
        sb_q.delete();
        grant_log.delete();
        repeat (20) begin
            tick();
            if (resp_valid != '0) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL busy_rst_dropped: got %0d responses required 0", seen); end
        mlat      = 2;
        req_valid = 4'b0100;
        drain(ok);
        n_tests++;
        if (!ok || grant_log.size() != 1 || grant_log[0] != 2) begin
            n_fail++; $display("FAIL busy_rst_represent: got %0d grants ok=%0d required one grant to 2", grant_log.size(), ok);
        end
    endtask

`ifdef MUL_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int  cyc = 0;
        int  n   = 0;
        bit  got = 0;
        bit  ok;
        stub_stuck = 1'b1;
        req_valid  = 4'b0010;
        while (!mul_start && cyc < 20) begin tick(); cyc++; end
        while (!got && n < 60) begin
            tick();
            n++;
            if (resp_valid != '0) begin
                got = 1;
                n_tests++;
                if (n != 22 || resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_product !== '0) begin
                    n_fail++;
                    $display("FAIL timeout_resp: got cyc=%0d valid=%b err=%b prod=%0h required 22 0010 1 0",
                             n, resp_valid, resp_err, resp_product);
                end
            end
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL timeout_missing: no response within 60 cycles"); end
        stub_stuck = 1'b0;
        drain(ok);
    endtask
`else
    task automatic test_timeout();
        int seen = 0;
        stub_stuck = 1'b1;
        req_valid  = 4'b0010;
        repeat (60) begin
            tick();
            if (resp_valid != '0) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL busy_wait: got %0d responses required 0", seen); end
        stub_stuck = 1'b0;
        apply_reset();
    endtask
`endif

    // Random traffic; the scoreboard checks every product, the task checks fairness.
    task automatic test_random();
        int issued   = 0;
        int cyc      = 0;
        int max_wait = 0;
        int waitc [NREQ];
        bit ok;
        foreach (waitc[i]) waitc[i] = 0;
        while (issued < 3000 && cyc < 60000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    a_v[i]       = ($urandom_range(0, 15) == 0) ? 16'sh8000 : WIDTH'($urandom);
                    b_v[i]       = ($urandom_range(0, 15) == 0) ? 16'sh8000 : WIDTH'($urandom);
                    req_valid[i] = 1'b1;
                    waitc[i]     = 0;
                end
            end
            mlat = $urandom_range(1, 4);
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                issued++;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) waitc[i] = 0;
                    else if (req_valid[i]) begin
                        waitc[i]++;
                        if (waitc[i] > max_wait) max_wait = waitc[i];
                    end
                end
            end
            req_valid = req_valid & ~req_ready;
        end
        n_tests++;
        if (issued < 3000) begin n_fail++; $display("FAIL random_progress: got %0d grants required 3000", issued); end
        n_tests++;
        if (max_wait > NREQ - 1) begin n_fail++; $display("FAIL random_starvation: got wait %0d required <= %0d", max_wait, NREQ - 1); end
        drain(ok);
        n_tests++;
        if (!ok || sb_q.size() != 0) begin n_fail++; $display("FAIL random_drain: got %0d outstanding required 0", sb_q.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_rr_skip();
        test_reset_busy();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
